// File: rtl/icache_controller_if.sv
// CPU fetch port and instruction-memory block port of the icache, bundled.
// Latency: n/a (wiring only).
// Backpressure: CPU_BUSYWAIT stalls the fetch stage, MEM_BUSYWAIT stalls the fill.
interface icache_controller_if;
    logic         CPU_READ;
    logic [31:0]  CPU_ADDR;
    logic         CPU_BUSYWAIT;
    logic [31:0]  CPU_INSTR;
    logic         MEM_READ_EN;
    logic [27:0]  MEM_ADDR;
    logic         MEM_BUSYWAIT;
    logic [127:0] MEM_READDATA;

    // CPU + instruction memory side (drives requests and block data)
    modport master (
        output CPU_READ, CPU_ADDR, MEM_BUSYWAIT, MEM_READDATA,
        input  CPU_BUSYWAIT, CPU_INSTR, MEM_READ_EN, MEM_ADDR
    );

    // Cache side
    modport slave (
        input  CPU_READ, CPU_ADDR, MEM_BUSYWAIT, MEM_READDATA,
        output CPU_BUSYWAIT, CPU_INSTR, MEM_READ_EN, MEM_ADDR
    );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache (2^INDEX_BITS lines x 128 bits) with block fill sequencer.
// Latency: hit returns the instruction combinationally; miss costs memory busy cycles + 3.
// Backpressure: CPU_BUSYWAIT held from miss detect through UPDATE; fill waits on MEM_BUSYWAIT.
// Optional: define ICACHE_STATS_EN to add HIT_COUNT / MISS_COUNT outputs.
module icache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    icache_controller_if.slave      bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]             HIT_COUNT,
    output logic [31:0]             MISS_COUNT
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Line storage; only the valid bits are reset, tags/data are don't-care while invalid.
    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [127:0]        data_mem [LINES];

    // Block address of the outstanding miss; the fill never looks at CPU_ADDR again.
    logic [27:0]           miss_addr;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;

    logic [INDEX_BITS-1:0] cpu_index;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic [1:0]            cpu_word;
    logic [127:0]          cpu_line;
    logic                  lookup_hit;

    logic         busywait;
    logic [31:0]  instr;
    logic         read_en;
    logic [27:0]  mem_addr;
    logic         miss_start;
    logic         hit_idle;

    // Byte offset bits never matter for 32-bit aligned fetches.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.CPU_ADDR[1:0];

    assign cpu_index  = bus.CPU_ADDR[4+INDEX_BITS-1:4];
    assign cpu_tag    = bus.CPU_ADDR[31:4+INDEX_BITS];
    assign cpu_word   = bus.CPU_ADDR[3:2];
    assign cpu_line   = data_mem[cpu_index];
    assign lookup_hit = bus.CPU_READ && valid[cpu_index] && (tag_mem[cpu_index] == cpu_tag);

    assign miss_index = miss_addr[INDEX_BITS-1:0];
    assign miss_tag   = miss_addr[27:INDEX_BITS];

    // State register; reset abandons any fill in progress.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all outputs; outputs are forced quiet while reset is held.
    always_comb begin
        state_next = state;
        busywait   = 1'b0;
        instr      = 32'h0;
        read_en    = 1'b0;
        mem_addr   = 28'h0;
        miss_start = 1'b0;
        hit_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.CPU_READ) begin
                    if (lookup_hit) begin
                        hit_idle = 1'b1;
                        instr    = cpu_line[{cpu_word, 5'b0} +: 32];
                    end else begin
                        busywait   = 1'b1;
                        miss_start = 1'b1;
                        state_next = MEM_READ;
                    end
                end
            end
            MEM_READ: begin
                busywait = 1'b1;
                read_en  = 1'b1;
                mem_addr = miss_addr;
                if (!bus.MEM_BUSYWAIT) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                busywait   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!RESET) begin
            busywait   = 1'b0;
            instr      = 32'h0;
            read_en    = 1'b0;
            mem_addr   = 28'h0;
            miss_start = 1'b0;
            hit_idle   = 1'b0;
        end
    end

    assign bus.CPU_BUSYWAIT = busywait;
    assign bus.CPU_INSTR    = instr;
    assign bus.MEM_READ_EN  = read_en;
    assign bus.MEM_ADDR     = mem_addr;

    // Capture the missing block address as the FSM leaves IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            miss_addr <= 28'h0;
        end else if (miss_start) begin
            miss_addr <= bus.CPU_ADDR[31:4];
        end
    end

    // Valid bits: cleared by reset, set when a line is installed.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
        end else if (state == UPDATE) begin
            valid[miss_index] <= 1'b1;
        end
    end

    // Tag/data install in UPDATE, one cycle after busywait drops so the whole block is stable.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= bus.MEM_READDATA;
        end
    end

`ifdef ICACHE_STATS_EN
    // Hit/miss statistics; the replay hit after a fill counts as a hit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HIT_COUNT  <= 32'h0;
            MISS_COUNT <= 32'h0;
        end else begin
            if (hit_idle) begin
                HIT_COUNT <= HIT_COUNT + 32'd1;
            end
            if (miss_start) begin
                MISS_COUNT <= MISS_COUNT + 32'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = hit_idle;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a fixed-latency block memory model.
// Memory word at byte address a holds a ^ 32'hC0DE0000; data is garbage until busywait drops.
module tb_icache_controller;

    localparam int MEM_LAT = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    icache_controller_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_controller #(.INDEX_BITS(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT  (hit_count),
        .MISS_COUNT (miss_count)
`endif
    );

    // Instruction memory model: busy for MEM_LAT cycles of a read, data valid once served.
    int          mem_cnt = 0;
    logic        data_ok = 1'b0;
    logic [27:0] data_addr = 28'h0;

    function automatic logic [127:0] block_of(input logic [27:0] a);
        logic [127:0] b;
        for (int i = 0; i < 4; i++) begin
            b[i*32 +: 32] = ({a, 4'h0} + 32'(i * 4)) ^ 32'hC0DE_0000;
        end
        return b;
    endfunction

    always @(posedge CLK) begin
        if (bus.MEM_READ_EN) begin
            mem_cnt <= mem_cnt + 1;
            if (mem_cnt == MEM_LAT) begin
                data_ok   <= 1'b1;
                data_addr <= bus.MEM_ADDR;
            end else if (mem_cnt == 0) begin
                data_ok <= 1'b0;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    assign bus.MEM_BUSYWAIT = bus.MEM_READ_EN && (mem_cnt < MEM_LAT);
    assign bus.MEM_READDATA = data_ok ? block_of(data_addr) : {4{32'hBAD0_BAD0}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts cycles until the stall drops, starting from a MEM_READ cycle.
    task automatic wait_fill(output int n);
        n = 0;
        while (bus.CPU_BUSYWAIT === 1'b1 && n < 40) begin
            tick();
            #1;
            n++;
        end
    endtask

    logic [31:0] hit_addr [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] hit_data [3] = '{32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};

    initial begin
        int n;
        int k;
        bus.CPU_READ = 1'b1;
        bus.CPU_ADDR = 32'h0;

        // Reset held: everything quiet even with a pending fetch.
        #12;
        check("rst_busy",   32'(bus.CPU_BUSYWAIT), 32'h0);
        check("rst_rd_en",  32'(bus.MEM_READ_EN),  32'h0);
        check("rst_maddr",  32'(bus.MEM_ADDR),     32'h0);
        check("rst_instr",  bus.CPU_INSTR,         32'h0);

        // First miss on PC 0.
        tick();
        RESET = 1'b1;
        #1;
        check("miss0_busy",  32'(bus.CPU_BUSYWAIT), 32'h1);
        check("miss0_rd_en", 32'(bus.MEM_READ_EN),  32'h0);
        tick();
        #1;
        check("fill0_rd_en", 32'(bus.MEM_READ_EN), 32'h1);
        check("fill0_maddr", 32'(bus.MEM_ADDR),    32'h0);
        wait_fill(n);
        check("fill0_penalty", 32'(n + 1), 32'(MEM_LAT + 3));
        check("fill0_instr",   bus.CPU_INSTR, 32'hC0DE_0000);

        // Remaining words of block 0 hit back-to-back.
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.CPU_ADDR = hit_addr[i];
            #1;
            check("hit_busy",  32'(bus.CPU_BUSYWAIT), 32'h0);
            check("hit_instr", bus.CPU_INSTR,         hit_data[i]);
            check("hit_rd_en", 32'(bus.MEM_READ_EN),  32'h0);
        end

        // Same index, different tag: replaces line 0.
        tick();
        bus.CPU_ADDR = 32'h80;
        #1;
        check("conf_busy", 32'(bus.CPU_BUSYWAIT), 32'h1);
        tick();
        #1;
        check("conf_maddr", 32'(bus.MEM_ADDR), 32'h8);
        wait_fill(n);
        check("conf_penalty", 32'(n + 1), 32'(MEM_LAT + 3));
        check("conf_instr",   bus.CPU_INSTR, 32'hC0DE_0080);
`ifdef ICACHE_STATS_EN
        // Hits so far: replay of 0x0, then 0x4, 0x8, 0xC; misses 0x0 and 0x80.
        check("stat_hits",   hit_count,  32'd4);
        check("stat_misses", miss_count, 32'd2);
`endif
        tick();
        bus.CPU_ADDR = 32'h0;
        #1;
        check("evict_busy", 32'(bus.CPU_BUSYWAIT), 32'h1);
        tick();
        #1;
        wait_fill(n);
        check("refill_instr", bus.CPU_INSTR, 32'hC0DE_0000);

        // Reset in the middle of a fill.
        tick();
        bus.CPU_ADDR = 32'h90;
        #1;
        tick();
        #1;
        check("mid_rd_en", 32'(bus.MEM_READ_EN), 32'h1);
        RESET = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(bus.MEM_READ_EN),  32'h0);
        check("mid_rst_busy",  32'(bus.CPU_BUSYWAIT), 32'h0);
        tick();
        bus.CPU_ADDR = 32'h0;
        RESET = 1'b1;
        #1;
        check("post_rst_miss", 32'(bus.CPU_BUSYWAIT), 32'h1);
        tick();
        #1;
        wait_fill(n);
        check("post_rst_instr", bus.CPU_INSTR, 32'hC0DE_0000);

        // PC changes during MEM_READ: the original block is still the one filled.
        tick();
        bus.CPU_ADDR = 32'h10;
        #1;
        tick();
        #1;
        check("chg_maddr1", 32'(bus.MEM_ADDR), 32'h1);
        bus.CPU_ADDR = 32'h20;
        #1;
        k = 0;
        while (bus.MEM_READ_EN === 1'b1 && k < 20) begin
            tick();
            #1;
            k++;
        end
        check("chg_fill_end", 32'(k < 20), 32'h1);
        tick();
        #1;
        check("chg_miss2_busy",  32'(bus.CPU_BUSYWAIT), 32'h1);
        check("chg_miss2_rd_en", 32'(bus.MEM_READ_EN),  32'h0);
        tick();
        #1;
        check("chg_maddr2", 32'(bus.MEM_ADDR), 32'h2);
        wait_fill(n);
        check("chg_instr2", bus.CPU_INSTR, 32'hC0DE_0020);
        tick();
        bus.CPU_ADDR = 32'h14;
        #1;
        check("chg_hit1_busy",  32'(bus.CPU_BUSYWAIT), 32'h0);
        check("chg_hit1_instr", bus.CPU_INSTR,         32'hC0DE_0014);

        // Idle fetch port: no stall, no memory traffic.
        tick();
        bus.CPU_READ = 1'b0;
        bus.CPU_ADDR = 32'h300;
        #1;
        check("noread_busy",  32'(bus.CPU_BUSYWAIT), 32'h0);
        check("noread_rd_en", 32'(bus.MEM_READ_EN),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
